// File: rtl/dwc_error_monitor.sv
// Purpose: classifies DwC compare mismatches as transient or permanent and keeps error statistics.
// Latency: one cycle; every output is registered and reflects the sample presented on the previous edge.
// Backpressure: none; always accepts, and cycles with port_valid low hold all state.
// Optional feature macro: DWC_MON_FIRST_CAPTURE_EN (port_err_chan keeps the first mismatch mask instead of the last).
module dwc_error_monitor #(
  parameter int WIDTH  = 4,
  parameter int THRESH = 3,
  parameter int CNT_W  = 8
) (
  input  logic             port_clk,
  input  logic             port_rst_n,
  input  logic             port_valid,
  input  logic [WIDTH-1:0] port_match,
  input  logic             port_clear,
  output logic             port_error,
  output logic             port_fault,
  output logic [1:0]       port_state,
  output logic [CNT_W-1:0] port_err_cnt,
  output logic [WIDTH-1:0] port_err_chan
);

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_TRANSIENT = 2'b01,
    ST_FAULT     = 2'b10
  } state_t;

  localparam logic [3:0] THRESH_L = 4'(THRESH);

  state_t             state_q, state_d;
  logic [3:0]         consec_q, consec_d;
  logic [3:0]         consec_inc;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   chan_q, chan_d;
  logic               mm;
  logic               all_match_v;

  assign mm          = port_valid & ~(&port_match);
  assign all_match_v = port_valid & (&port_match);
  // The run counter never needs to exceed THRESH, but saturate so it cannot wrap back to zero.
  assign consec_inc  = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;

  // Next-state and statistics update; clear wins over any sample in the same cycle.
  always_comb begin
    state_d  = state_q;
    consec_d = consec_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    chan_d   = chan_q;
    if (port_clear) begin
      state_d  = ST_OK;
      consec_d = 4'd0;
      err_d    = 1'b0;
      cnt_d    = '0;
      chan_d   = '0;
    end else begin
      if (port_valid) begin
        err_d = mm;
      end
      if (mm && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`ifdef DWC_MON_FIRST_CAPTURE_EN
      // A mismatch mask is never zero, so an all-zero register means nothing captured yet.
      if (mm && (chan_q == '0)) begin
        chan_d = ~port_match;
      end
`else
      if (mm) begin
        chan_d = ~port_match;
      end
`endif
      case (state_q)
        ST_OK: begin
          if (mm) begin
            state_d  = ST_TRANSIENT;
            consec_d = consec_inc;
          end
        end
        ST_TRANSIENT: begin
          if (mm) begin
            consec_d = consec_inc;
            if (consec_inc >= THRESH_L) begin
              state_d = ST_FAULT;
            end
          end else if (all_match_v) begin
            consec_d = 4'd0;
            state_d  = ST_OK;
          end
        end
        ST_FAULT: begin
          // Absorbing: the run counter freezes, only clear or reset leaves.
          state_d = ST_FAULT;
        end
        default: begin
          state_d  = ST_OK;
          consec_d = 4'd0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge port_clk or negedge port_rst_n) begin
    if (!port_rst_n) begin
      state_q  <= ST_OK;
      consec_q <= 4'd0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      chan_q   <= '0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      chan_q   <= chan_d;
    end
  end

  assign port_error    = err_q;
  assign port_fault    = (state_q == ST_FAULT);
  assign port_state    = state_q;
  assign port_err_cnt  = cnt_q;
  assign port_err_chan = chan_q;

endmodule

// File: tb/tb_dwc_error_monitor.sv
// Purpose: randomized and directed check of dwc_error_monitor against a behavioural model.
// Latency: model is advanced at each rising edge and compared on the falling edge.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_dwc_error_monitor;

  localparam int WIDTH  = 4;
  localparam int THRESH = 3;
  localparam int CNT_W  = 8;

  logic             port_clk;
  logic             port_rst_n;
  logic             port_valid;
  logic [WIDTH-1:0] port_match;
  logic             port_clear;
  logic             port_error;
  logic             port_fault;
  logic [1:0]       port_state;
  logic [CNT_W-1:0] port_err_cnt;
  logic [WIDTH-1:0] port_err_chan;

  dwc_error_monitor #(.WIDTH(WIDTH), .THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .port_clk      (port_clk),
    .port_rst_n    (port_rst_n),
    .port_valid    (port_valid),
    .port_match    (port_match),
    .port_clear    (port_clear),
    .port_error    (port_error),
    .port_fault    (port_fault),
    .port_state    (port_state),
    .port_err_cnt  (port_err_cnt),
    .port_err_chan (port_err_chan)
  );

  initial port_clk = 1'b0;
  always #5 port_clk = ~port_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Behavioural model: totals, current mismatch run length, sticky fault, mask history.
  int               m_total;
  int               m_run;
  bit               m_fault;
  bit               m_err;
  bit               m_have;
  logic [WIDTH-1:0] m_first;
  logic [WIDTH-1:0] m_last;

  task automatic model_reset();
    m_total = 0; m_run = 0; m_fault = 0; m_err = 0; m_have = 0;
    m_first = '0; m_last = '0;
  endtask

  task automatic model_step(input logic v, input logic [WIDTH-1:0] m, input logic c);
    if (c) begin
      model_reset();
    end else if (v) begin
      if (m != {WIDTH{1'b1}}) begin
        m_err = 1;
        m_total++;
        if (!m_fault) m_run++;
        if (m_run >= THRESH) m_fault = 1;
        m_last = ~m;
        if (!m_have) begin
          m_first = ~m;
          m_have  = 1;
        end
      end else begin
        m_err = 0;
        if (!m_fault) m_run = 0;
      end
    end
  endtask

  function automatic logic [1:0] exp_state();
    if (m_fault) return 2'b10;
    return (m_run > 0) ? 2'b01 : 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] exp_cnt();
    int lim;
    lim = (1 << CNT_W) - 1;
    return CNT_W'((m_total > lim) ? lim : m_total);
  endfunction

  function automatic logic [WIDTH-1:0] exp_chan();
`ifdef DWC_MON_FIRST_CAPTURE_EN
    return m_first;
`else
    return m_last;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge port_clk) begin
    if (chk_en) begin
      chk("model_error", 32'(port_error),    32'(m_err));
      chk("model_fault", 32'(port_fault),    32'(m_fault));
      chk("model_state", 32'(port_state),    32'(exp_state()));
      chk("model_cnt",   32'(port_err_cnt),  32'(exp_cnt()));
      chk("model_chan",  32'(port_err_chan), 32'(exp_chan()));
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] m, input logic c);
    port_valid = v;
    port_match = m;
    port_clear = c;
    @(posedge port_clk);
    model_step(v, m, c);
    @(negedge port_clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_error"}, 32'(port_error),    32'd0);
    chk({nm, "_fault"}, 32'(port_fault),    32'd0);
    chk({nm, "_state"}, 32'(port_state),    32'd0);
    chk({nm, "_cnt"},   32'(port_err_cnt),  32'd0);
    chk({nm, "_chan"},  32'(port_err_chan), 32'd0);
  endtask

  initial begin
    logic             rv;
    logic             rc;
    logic [WIDTH-1:0] rm;

    port_rst_n = 1'b0;
    port_valid = 1'b0;
    port_match = '1;
    port_clear = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset");
    @(negedge port_clk);
    @(negedge port_clk);
    port_rst_n = 1'b1;
    chk_en = 1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) drive(1'b0, 4'b0000, 1'b0);
    chk_all_zero("idle");

    // Single transient.
    drive(1'b1, 4'b1011, 1'b0);
    chk("tr_error", 32'(port_error),    32'd1);
    chk("tr_state", 32'(port_state),    32'd1);
    chk("tr_cnt",   32'(port_err_cnt),  32'd1);
    chk("tr_chan",  32'(port_err_chan), 32'h4);
    drive(1'b1, 4'b1111, 1'b0);
    chk("tr_recover_error", 32'(port_error), 32'd0);
    chk("tr_recover_state", 32'(port_state), 32'd0);

    // Permanent fault with invalid cycles interleaved.
    drive(1'b0, 4'b1111, 1'b1);
    drive(1'b1, 4'b1110, 1'b0);
    drive(1'b0, 4'b1111, 1'b0);
    drive(1'b1, 4'b1110, 1'b0);
    chk("pf_second_state", 32'(port_state), 32'd1);
    chk("pf_second_fault", 32'(port_fault), 32'd0);
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b1, 4'b1110, 1'b0);
    chk("pf_state", 32'(port_state),   32'd2);
    chk("pf_fault", 32'(port_fault),   32'd1);
    chk("pf_cnt",   32'(port_err_cnt), 32'd3);
    drive(1'b1, 4'b1111, 1'b0);
    chk("pf_sticky_fault", 32'(port_fault), 32'd1);
    chk("pf_sticky_error", 32'(port_error), 32'd0);

    // Clear together with a mismatch from FAULT.
    drive(1'b1, 4'b0000, 1'b1);
    chk_all_zero("clr_mm");

    // Counter saturation.
    for (int i = 0; i < 300; i++) drive(1'b1, 4'($urandom_range(0, 14)), 1'b0);
    chk("sat_cnt",   32'(port_err_cnt), 32'd255);
    chk("sat_fault", 32'(port_fault),   32'd1);

    // Capture mode.
    drive(1'b0, 4'b1111, 1'b1);
    drive(1'b1, 4'b0111, 1'b0);
    drive(1'b1, 4'b1101, 1'b0);
`ifdef DWC_MON_FIRST_CAPTURE_EN
    chk("cap_chan", 32'(port_err_chan), 32'h8);
`else
    chk("cap_chan", 32'(port_err_chan), 32'h2);
`endif
    // Asynchronous reset mid-sequence, observed before any clock edge.
    port_valid = 1'b1;
    port_match = 4'b1110;
    #2;
    port_rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("arst");
    @(negedge port_clk);
    port_rst_n = 1'b1;
    drive(1'b0, 4'b1111, 1'b0);
    chk_all_zero("arst_hold");

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rm = ($urandom_range(0, 9) < 5) ? 4'b1111 : 4'($urandom_range(0, 14));
      rc = ($urandom_range(0, 60) == 0);
      drive(rv, rm, rc);
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dwc_error_monitor.md
Name: dwc_error_monitor

Overview:
Sequential error-handling stage placed directly downstream of the duplication-with-comparison (DwC) detection cells. It samples a vector of per-channel compare-match bits. Each bit is 1 when the two copies agree and 0 when they mismatch. The block classifies mismatches as transient or permanent and exposes registered error, fault and statistics outputs to the system controller.

Parameters:
WIDTH, 4, number of DwC channels monitored (1..32)
THRESH, 3, consecutive mismatching valid samples that declare a permanent fault (2..15)
CNT_W, 8, width of the saturating mismatch-event counter

Ports:
port_clk  input  1  system clock, rising edge
port_rst_n  input  1  asynchronous active-low reset
port_valid  input  1  port_match is meaningful this cycle
port_match  input  WIDTH  per-channel compare result, 1 = agree, 0 = mismatch
port_clear  input  1  synchronous clear of fault, counters and state
port_error  output  1  registered: previous valid sample mismatched
port_fault  output  1  sticky permanent-fault flag
port_state  output  2  FSM state encoding: 00 OK, 01 TRANSIENT, 10 FAULT
port_err_cnt  output  CNT_W  saturating count of mismatching valid samples
port_err_chan  output  WIDTH  channel mask of the most relevant mismatch (see Optional Feature)

Behaviour:
- Reset (port_rst_n = 0, asynchronous): all outputs 0, state OK, consecutive counter 0.
- Mismatch event: mm = port_valid & ~&port_match. If port_valid = 0, the cycle is ignored and holds all state.
- Latency: all outputs are registered and reflect a sample one cycle after it is presented.
- port_error: set to mm on every valid cycle; holds its value on invalid cycles.
- port_err_cnt: +1 on each mm; saturates at 2^CNT_W-1, with no wrap.
- Consecutive counter (internal, 4 bits): +1 on mm; reset to 0 on a valid cycle with all bits matching; holds on invalid cycles.
- FSM:
  - OK -> TRANSIENT on mm.
  - TRANSIENT -> OK on a valid all-match sample.
  - TRANSIENT -> FAULT when mm and the consecutive count reaches THRESH (the THRESH-th consecutive mismatch).
  - TRANSIENT stays TRANSIENT on further mm below THRESH.
  - FAULT is absorbing; only port_clear or reset leaves it.
- port_fault: 1 exactly while the state is FAULT. It sets in the same cycle the state enters FAULT.
- In FAULT: port_err_cnt and port_error keep updating; the consecutive counter freezes.
- port_clear:
  - Synchronous. Next cycle: state OK, all counters 0, port_error 0, port_fault 0, port_err_chan 0.
  - Clear has priority over a simultaneous mm; that sample is discarded entirely.
- Reset mid-operation: returns to reset values immediately, with no pending state retained.
- WIDTH = 1 is legal; the mask is a single bit.

Optional Feature:
Macro DWC_MON_FIRST_CAPTURE_EN.
- Defined: port_err_chan latches ~port_match of the first mismatching sample after reset or clear. It then holds until port_clear or reset, so later mismatches do not overwrite it.
- Undefined: port_err_chan is updated with ~port_match on every mm, i.e. the last mismatch mask; it holds on match or invalid cycles.

Test Plan:
- Reset then idle: port_valid = 0 for 10 cycles -> all outputs 0, port_state = 00.
- Single transient, WIDTH = 4: one valid sample with port_match = 4'b1011, then a valid 4'b1111.
  - Cycle +1: port_error = 1, port_state = 01, port_err_cnt = 1, port_err_chan = 4'b0100.
  - Cycle +2: port_error = 0, port_state = 00.
- Permanent fault, THRESH = 3: three consecutive valid samples 4'b1110, with invalid cycles interleaved.
  - Invalid cycles do not break the run.
  - After the third sample: port_state = 10, port_fault = 1, port_err_cnt = 3.
  - A following all-match sample leaves port_fault = 1.
- Saturation, CNT_W = 8: 300 mismatching samples -> port_err_cnt stops at 255 with no wrap; port_fault = 1.
- Clear vs mismatch in the same cycle: from FAULT, assert port_clear together with a valid mismatch -> next cycle all outputs 0 and state OK; the mismatch is not counted.
- Capture mode: mismatches 4'b0111 then 4'b1101.
  - With DWC_MON_FIRST_CAPTURE_EN: port_err_chan = 4'b1000.
  - Without it: port_err_chan = 4'b0010.
  - Async reset asserted mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
